// File: rtl/dram_read_checker.sv
// Passive DDR read-data checker: queues snooped read addresses in order and
// compares each returned beat against an address-derived pattern.

module dram_read_checker_lane #(
  parameter int          Lane = 0,
  parameter logic [31:0] Salt = 32'hA5C3_0F1E
) (
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        mismatch
);
  logic [31:0] expected;
  assign expected = (addr + 32'(Lane)) ^ Salt;
  assign mismatch = (data != expected);
endmodule

module dram_read_checker #(
  parameter int                 DDRDWidth = 512,
  parameter int                 DDRAWidth = 28,
  parameter int                 DDRCWidth = 3,
  parameter logic [DDRCWidth-1:0] CmdRead = 3'b001,
  parameter logic [31:0]        Salt      = 32'hA5C3_0F1E,
  parameter int                 QDepth    = 16,
  localparam int                NL        = DDRDWidth / 32,
  localparam int                QAW       = $clog2(QDepth)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DDRCWidth-1:0] Command,
  input  logic [DDRAWidth-1:0] Address,
  input  logic                 CommandValid,
  input  logic                 CommandReady,
  input  logic [DDRDWidth-1:0] ReadData,
  input  logic                 ReadDataValid,
  input  logic                 ClearStats,
  output logic                 Error_DataMismatch,
  output logic                 Error_MultiLane,
  output logic                 Error_QOverflow,
  output logic                 Error_Unexpected,
  output logic [31:0]          CheckedCount,
  output logic [15:0]          MismatchCount,
  output logic [DDRAWidth-1:0] LastBadAddress,
  output logic [NL-1:0]        LastBadLanes,
  output logic [QAW:0]         QLevel
);
  logic [DDRAWidth-1:0] q_mem [QDepth];
  logic [QAW-1:0]       wr_ptr, rd_ptr;
  logic [QAW:0]         q_cnt;
  logic                 q_full, q_empty;
  logic                 push_req, push_ok, pop;
  logic                 overflow_ev, unexp_ev;
  logic [DDRAWidth-1:0] head_addr;
  logic [NL-1:0]        lane_bad;

  logic                 s1_vld;
  logic [NL-1:0]        s1_vec;
  logic [DDRAWidth-1:0] s1_addr;

  assign q_full      = (q_cnt == (QAW+1)'(QDepth));
  assign q_empty     = (q_cnt == '0);
  assign push_req    = CommandValid & CommandReady & (Command == CmdRead);
  // No bypass: a beat only pops what was queued before this cycle.
  assign pop         = ReadDataValid & ~q_empty;
  assign push_ok     = push_req & (~q_full | pop);
  assign overflow_ev = push_req & ~push_ok;
  assign unexp_ev    = ReadDataValid & q_empty;
  assign head_addr   = q_mem[rd_ptr];
  assign QLevel      = q_cnt;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    dram_read_checker_lane #(.Lane(gi), .Salt(Salt)) u_lane (
      .addr     (32'(head_addr)),
      .data     (ReadData[32*gi +: 32]),
      .mismatch (lane_bad[gi])
    );
  end

  always_ff @(posedge Clock) begin
    if (push_ok) q_mem[wr_ptr] <= Address;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      q_cnt <= q_cnt + (QAW+1)'(push_ok) - (QAW+1)'(pop);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_vld  <= 1'b0;
      s1_vec  <= '0;
      s1_addr <= '0;
    end else begin
      s1_vld  <= pop;
      s1_vec  <= lane_bad;
      s1_addr <= head_addr;
    end
  end

  // Clear beats any same-cycle stage-2 update; stage 1 is left untouched.
  always_ff @(posedge Clock) begin
    if (Reset || ClearStats) begin
      Error_DataMismatch <= 1'b0;
      Error_MultiLane    <= 1'b0;
      Error_QOverflow    <= 1'b0;
      Error_Unexpected   <= 1'b0;
      CheckedCount       <= '0;
      MismatchCount      <= '0;
      LastBadAddress     <= '0;
      LastBadLanes       <= '0;
    end else begin
      if (overflow_ev) Error_QOverflow  <= 1'b1;
      if (unexp_ev)    Error_Unexpected <= 1'b1;
      if (s1_vld) begin
        if (CheckedCount != '1) CheckedCount <= CheckedCount + 1'b1;
        if (|s1_vec) begin
          if (MismatchCount != '1) MismatchCount <= MismatchCount + 1'b1;
          LastBadAddress     <= s1_addr;
          LastBadLanes       <= s1_vec;
          Error_DataMismatch <= 1'b1;
          // More than one bit set iff clearing the lowest set bit leaves any.
          if (|(s1_vec & (s1_vec - 1'b1))) Error_MultiLane <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dram_read_checker.sv
// Directed bench for dram_read_checker: vector table of single read/beat
// pairs plus hand-written sequences for queue, clear and reset corners.

module tb_dram_read_checker;
  localparam logic [31:0] SALT = 32'hA5C3_0F1E;
  localparam logic [2:0]  RD   = 3'b001;
  localparam logic [2:0]  WR   = 3'b000;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   cmd;
  logic [27:0]  addr;
  logic         cv, cr, rv, clr;
  logic [511:0] rdata;
  logic         e_dm, e_ml, e_ov, e_un;
  logic [31:0]  chk_cnt;
  logic [15:0]  mm_cnt;
  logic [27:0]  bad_addr;
  logic [15:0]  bad_lanes;
  logic [4:0]   qlvl;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  dram_read_checker dut (
    .Clock(clk), .Reset(rst), .Command(cmd), .Address(addr),
    .CommandValid(cv), .CommandReady(cr), .ReadData(rdata),
    .ReadDataValid(rv), .ClearStats(clr),
    .Error_DataMismatch(e_dm), .Error_MultiLane(e_ml),
    .Error_QOverflow(e_ov), .Error_Unexpected(e_un),
    .CheckedCount(chk_cnt), .MismatchCount(mm_cnt),
    .LastBadAddress(bad_addr), .LastBadLanes(bad_lanes), .QLevel(qlvl)
  );

  typedef struct {
    logic [27:0] a;
    logic [15:0] flip;
    logic        x_bad;
    logic [15:0] x_lanes;
    logic [27:0] x_addr;
    logic        x_multi;
  } vec_t;

  function automatic logic [511:0] pat(input logic [27:0] a, input logic [15:0] flip);
    logic [511:0] d;
    logic [31:0]  l;
    for (int i = 0; i < 16; i++) begin
      l = ({4'h0, a} + 32'(i)) ^ SALT;
      if (flip[i]) l = l ^ 32'h0000_0020;
      d[32*i +: 32] = l;
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Applies one cycle of inputs starting at a negedge; returns at the next negedge.
  task automatic step(input logic c_v, input logic [2:0] c, input logic [27:0] a,
                      input logic r_v, input logic [511:0] d, input logic cl);
    cv = c_v; cmd = c; addr = a; rv = r_v; rdata = d; clr = cl;
    @(negedge clk);
    cv = 1'b0; rv = 1'b0; clr = 1'b0;
  endtask

  task automatic push(input logic [27:0] a);
    step(1'b1, RD, a, 1'b0, '0, 1'b0);
  endtask

  task automatic beat(input logic [27:0] a, input logic [15:0] flip);
    step(1'b0, RD, '0, 1'b1, pat(a, flip), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_stats();
    step(1'b0, RD, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic chk_zero_stats(input string tag);
    chk({tag, ".checked"},  chk_cnt,   0);
    chk({tag, ".mismatch"}, mm_cnt,    0);
    chk({tag, ".flags"},    {e_dm, e_ml, e_ov, e_un}, 0);
    chk({tag, ".badaddr"},  bad_addr,  0);
    chk({tag, ".badlanes"}, bad_lanes, 0);
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{28'h0000200,  16'h0008, 1'b1, 16'h0008, 28'h0000200,  1'b0};
    vt[1] = '{28'h0000300,  16'h8001, 1'b1, 16'h8001, 28'h0000300,  1'b1};
    vt[2] = '{28'h0000400,  16'h0000, 1'b0, 16'h0000, 28'h0000000,  1'b0};
    vt[3] = '{28'hFFFFFFF,  16'h0100, 1'b1, 16'h0100, 28'hFFFFFFF,  1'b0};
    vt[4] = '{28'h0000000,  16'hFFFF, 1'b1, 16'hFFFF, 28'h0000000,  1'b1};

    rst = 1'b1; cmd = '0; addr = '0; cv = 1'b0; cr = 1'b1; rv = 1'b0;
    rdata = '0; clr = 1'b0;
    idle(3);
    rst = 1'b0;
    chk_zero_stats("reset");
    chk("reset.qlevel", qlvl, 0);

    // Three reads, beats on consecutive cycles; a write is ignored.
    push(28'h100); push(28'h140);
    step(1'b1, WR, 28'h7C0, 1'b0, '0, 1'b0);
    push(28'h180);
    chk("seq1.qlevel3", qlvl, 3);
    beat(28'h100, 0); beat(28'h140, 0); beat(28'h180, 0);
    idle(1);
    chk("seq1.checked",  chk_cnt, 3);
    chk("seq1.mismatch", mm_cnt,  0);
    chk("seq1.flags",    {e_dm, e_ml, e_ov, e_un}, 0);
    chk("seq1.qlevel0",  qlvl,    0);

    for (int i = 0; i < 5; i++) begin
      clear_stats();
      push(vt[i].a);
      beat(vt[i].a, vt[i].flip);
      chk($sformatf("vec%0d.early", i), chk_cnt, 0);
      idle(1);
      chk($sformatf("vec%0d.checked", i),  chk_cnt,   1);
      chk($sformatf("vec%0d.mismatch", i), mm_cnt,    16'(vt[i].x_bad));
      chk($sformatf("vec%0d.dm", i),       e_dm,      vt[i].x_bad);
      chk($sformatf("vec%0d.multi", i),    e_ml,      vt[i].x_multi);
      chk($sformatf("vec%0d.lanes", i),    bad_lanes, vt[i].x_lanes);
      chk($sformatf("vec%0d.addr", i),     bad_addr,  vt[i].x_addr);
      chk($sformatf("vec%0d.qlevel", i),   qlvl,      0);
    end

    // Overflow: 17 reads into a 16-deep queue, last one dropped.
    clear_stats();
    for (int i = 0; i < 17; i++) push(28'h1000 + 28'(i*64));
    chk("ovf.flag",   e_ov, 1);
    chk("ovf.qlevel", qlvl, 16);
    for (int i = 0; i < 16; i++) beat(28'h1000 + 28'(i*64), 0);
    idle(1);
    chk("ovf.checked",  chk_cnt, 16);
    chk("ovf.mismatch", mm_cnt,  0);
    chk("ovf.qlevel0",  qlvl,    0);

    // Full queue with push and pop together: no overflow.
    clear_stats();
    for (int i = 0; i < 16; i++) push(28'h2000 + 28'(i*64));
    step(1'b1, RD, 28'h3000, 1'b1, pat(28'h2000, 0), 1'b0);
    chk("pp.noovf",  e_ov, 0);
    chk("pp.qlevel", qlvl, 16);
    for (int i = 1; i < 16; i++) beat(28'h2000 + 28'(i*64), 0);
    beat(28'h3000, 0);
    idle(1);
    chk("pp.checked",  chk_cnt, 17);
    chk("pp.mismatch", mm_cnt,  0);
    chk("pp.qlevel0",  qlvl,    0);

    // Beat with empty queue, then beat plus push on an empty queue.
    clear_stats();
    beat(28'h0, 0);
    idle(1);
    chk("unexp.flag",    e_un,    1);
    chk("unexp.checked", chk_cnt, 0);
    step(1'b1, RD, 28'h500, 1'b1, pat(28'h500, 0), 1'b0);
    idle(1);
    chk("nobyp.checked", chk_cnt, 0);
    chk("nobyp.qlevel",  qlvl,    1);
    beat(28'h500, 0);
    idle(1);
    chk("nobyp.drain",   chk_cnt, 1);
    chk("nobyp.mm",      mm_cnt,  0);

    // ClearStats coinciding with stage 2 of a bad beat.
    clear_stats();
    push(28'h600); push(28'h640);
    beat(28'h600, 16'h0002);
    clear_stats();
    chk_zero_stats("clr2");
    chk("clr2.qlevel", qlvl, 1);
    beat(28'h640, 0);
    idle(1);
    chk("clr2.after", chk_cnt, 1);

    // ClearStats coinciding with stage 1: beat still lands afterwards.
    push(28'h680);
    step(1'b0, RD, '0, 1'b1, pat(28'h680, 16'h0004), 1'b1);
    idle(1);
    chk("clr1.checked", chk_cnt,   1);
    chk("clr1.mm",      mm_cnt,    1);
    chk("clr1.lanes",   bad_lanes, 16'h0004);
    chk("clr1.addr",    bad_addr,  28'h680);

    // Reset with queued reads and a beat in flight.
    for (int i = 0; i < 5; i++) push(28'h700 + 28'(i*64));
    beat(28'h700, 16'h0001);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst.qlevel", qlvl, 0);
    chk_zero_stats("rst");
    idle(2);
    chk("rst.inflight", chk_cnt, 0);
    beat(28'h740, 0);
    idle(1);
    chk("rst.unexp", e_un, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
